mem_port_arbiter: RTL and testbench

- Shares the processor's single 32-bit memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Both stages previously drove mem_addr/mem_w_data/mem_*_enable directly. This block owns those outputs and serialises accesses.
- Memory has fixed multi-cycle latency (byte-serial backing store, 4 clk per word).
- Data wins by default; a starvation guard forces a fetch grant after a bounded streak of data grants.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/arb_latency_counter.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared types for the memory-port arbiter and its helpers
// Rev 1.0 : initial release
// ============================================================================
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/arb_latency_counter.sv
`default_nettype none
// ============================================================================
// arb_latency_counter : loadable down-counter with zero flag
// Rev 1.0 : initial release
// ============================================================================
module arb_latency_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : serialises IF-stage fetches and MEM-stage loads/stores
//                    onto one fixed-latency memory port, data-first with a
//                    starvation guard for fetches.
// Rev 1.0 : initial release
// ============================================================================
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LATENCY  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  output logic [WORD_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_done,
  output logic              busy,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_w_data,
  input  logic [WORD_W-1:0] mem_r_data,
  output logic              mem_w_enable,
  output logic              mem_r_enable
);

  localparam int CNT_W    = $clog2(MEM_LATENCY) + 1;
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [WORD_W-1:0]   i_rdata_q, i_rdata_d;
  logic [WORD_W-1:0]   d_rdata_q, d_rdata_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  // The counter is loaded as the grant is taken, so GRANT is already the
  // first latency cycle and a latency of 1 goes GRANT -> DONE directly.
  arb_latency_counter #(
    .WIDTH (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      streak_q  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      streak_q  <= streak_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    streak_d  = streak_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!i_req) begin
          streak_d = '0;
        end
        if (d_req && i_req && (streak_q == STREAK_MAX)) begin
          owner_d  = OWN_I;
          addr_d   = i_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          streak_d = '0;
          cnt_load = 1'b1;
          state_d  = GRANT;
        end else if (d_req) begin
          owner_d  = OWN_D;
          addr_d   = d_addr;
          we_d     = d_we;
          wdata_d  = d_wdata;
          cnt_load = 1'b1;
          state_d  = GRANT;
          if (i_req && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (i_req) begin
          owner_d  = OWN_I;
          addr_d   = i_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          streak_d = '0;
          cnt_load = 1'b1;
          state_d  = GRANT;
        end
      end
      GRANT, BUSY: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          if (owner_q == OWN_I) begin
            i_rdata_d = mem_r_data;
          end else if ((owner_q == OWN_D) && !we_q) begin
            d_rdata_d = mem_r_data;
          end
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_w_enable = 1'b0;
    mem_r_enable = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      GRANT, BUSY: begin
        busy         = 1'b1;
        mem_w_enable = we_q;
        mem_r_enable = !we_q;
      end
      DONE: begin
        busy   = 1'b1;
        i_done = (owner_q == OWN_I);
        d_done = (owner_q == OWN_D);
      end
      default: begin
      end
    endcase
  end

  assign mem_addr   = addr_q;
  assign mem_w_data = wdata_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : self-checking bench for mem_port_arbiter
// Rev 1.0 : initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int L0 = 4;
  localparam int L1 = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_w_data, mem_r_data;
  logic        i_done, d_done, busy, mem_w_enable, mem_r_enable;

  logic        i1_req, d1_req, d1_we;
  logic [31:0] i1_addr, d1_addr, d1_wdata;
  logic [31:0] i1_rdata, d1_rdata, mem1_addr, mem1_w_data, mem1_r_data;
  logic        i1_done, d1_done, busy1, mem1_w_enable, mem1_r_enable;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(L0), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .busy(busy),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
    .mem_w_enable(mem_w_enable), .mem_r_enable(mem_r_enable)
  );

  mem_port_arbiter #(.MEM_LATENCY(L1), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_req(i1_req), .i_addr(i1_addr), .i_rdata(i1_rdata), .i_done(i1_done),
    .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
    .d_rdata(d1_rdata), .d_done(d1_done), .busy(busy1),
    .mem_addr(mem1_addr), .mem_w_data(mem1_w_data), .mem_r_data(mem1_r_data),
    .mem_w_enable(mem1_w_enable), .mem_r_enable(mem1_r_enable)
  );

  // Memory model: word at addr reads as addr+3, valid only once the read
  // strobe has been held for the full latency; garbage before that.
  int hcnt0, hcnt1;
  always @(posedge clk) hcnt0 <= mem_r_enable ? hcnt0 + 1 : 0;
  always @(posedge clk) hcnt1 <= mem1_r_enable ? hcnt1 + 1 : 0;
  assign mem_r_data  = (mem_r_enable && hcnt0 >= L0 - 1) ? mem_addr + 32'd3 : 32'hBAD0_0000;
  assign mem1_r_data = (mem1_r_enable && hcnt1 >= L1 - 1) ? mem1_addr + 32'd3 : 32'hBAD0_0000;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a + 32'd3;
  endfunction

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } sb_t;

  sb_t sb[$];

  // Monitor: tracks each enable run and checks it against the scoreboard
  // entry popped on the matching done pulse.
  int          run;
  logic [31:0] run_addr, run_wdata, exp_i, exp_d;
  logic        run_we, both_seen;
  sb_t         e;

  always @(negedge clk) begin
    if (reset) begin
      run = 0; both_seen = 1'b0; exp_i = 32'h0; exp_d = 32'h0;
    end else begin
      if (mem_r_enable || mem_w_enable) begin
        if (run == 0) begin
          run_addr = mem_addr; run_wdata = mem_w_data; run_we = mem_w_enable;
        end
        if (mem_r_enable && mem_w_enable) both_seen = 1'b1;
        run++;
      end
      if (i_done || d_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {30'b0, i_done, d_done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_port", {30'b0, i_done, d_done}, e.is_d ? 32'd1 : 32'd2);
          check("mem_addr", run_addr, e.addr);
          check("mem_we", {31'b0, run_we}, {31'b0, e.we});
          if (e.we) check("mem_w_data", run_wdata, e.wdata);
          check("enable_cycles", 32'(run), 32'(L0));
          check("both_enables", {31'b0, both_seen}, 32'd0);
          if (!e.is_d) begin
            check("i_rdata", i_rdata, e.rdata); exp_i = e.rdata;
          end else if (!e.we) begin
            check("d_rdata", d_rdata, e.rdata); exp_d = e.rdata;
          end else begin
            check("d_rdata_store_hold", d_rdata, exp_d);
          end
        end
        run = 0; both_seen = 1'b0;
      end
    end
  end

  task automatic wait_done(input bit is_d, input int bound, output int cnt);
    logic seen;
    seen = 1'b0;
    cnt  = 0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if ((is_d ? d_done : i_done) === 1'b1) begin
        cnt = c; seen = 1'b1;
        break;
      end
    end
    if (!seen) check(is_d ? "d_done_timeout" : "i_done_timeout", {31'b0, seen}, 32'd1);
  endtask

  task automatic port_i(input int n, input logic [31:0] a0, output int lat0);
    int lat;
    lat0 = 0;
    for (int k = 0; k < n; k++) begin
      i_addr = a0 + 32'(4 * k);
      i_req  = 1'b1;
      wait_done(1'b0, 80, lat);
      if (k == 0) lat0 = lat;
      @(posedge clk); #1;
    end
    i_req = 1'b0;
  endtask

  task automatic port_d(input int n, input logic [31:0] a0, output int lat0);
    int lat;
    lat0 = 0;
    for (int k = 0; k < n; k++) begin
      d_addr = a0 + 32'(4 * k);
      d_we   = 1'b0;
      d_req  = 1'b1;
      wait_done(1'b1, 80, lat);
      if (k == 0) lat0 = lat;
      @(posedge clk); #1;
    end
    d_req = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vec[5];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, li, ld, cnt, en;
    logic ok;

    vec[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0013, 6};
    vec[1] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0, 32'h0000_0207, 6};
    vec[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 6};
    vec[3] = '{1'b0, 1'b0, 32'h2000_0000, 32'h0, 32'h2000_0003, 6};
    vec[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 6};

    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    i1_req = 1'b0; i1_addr = 32'h0; d1_req = 1'b0; d1_we = 1'b0; d1_addr = 32'h0; d1_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_w_data", mem_w_data, 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_ctrl", {27'b0, i_done, d_done, busy, mem_w_enable, mem_r_enable}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single accesses from an idle arbiter.
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{vec[k].is_d, vec[k].we, vec[k].addr, vec[k].wdata, vec[k].exp_rdata});
      if (vec[k].is_d) begin
        d_we = vec[k].we; d_addr = vec[k].addr; d_wdata = vec[k].wdata; d_req = 1'b1;
      end else begin
        i_addr = vec[k].addr; i_req = 1'b1;
      end
      wait_done(vec[k].is_d, 40, lat);
      check("single_latency", 32'(lat), 32'(vec[k].exp_lat));
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("i_rdata_hold", i_rdata, exp_i);
      check("d_rdata_hold", d_rdata, exp_d);
      @(posedge clk); #1;
    end

    // Simultaneous requests: data first, then fetch.
    sb.push_back('{1'b1, 1'b0, 32'h200, 32'h0, memf(32'h200)});
    sb.push_back('{1'b0, 1'b0, 32'h300, 32'h0, memf(32'h300)});
    fork
      port_d(1, 32'h200, ld);
      port_i(1, 32'h300, li);
    join
    check("both_d_latency", 32'(ld), 32'd6);
    check("both_i_latency", 32'(li), 32'd12);
    @(posedge clk); #1;

    // Starvation guard: four data grants, forced fetch, streak restarts.
    for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 1'b0, 32'h400 + 32'(4 * k), 32'h0, memf(32'h400 + 32'(4 * k))});
    sb.push_back('{1'b0, 1'b0, 32'h500, 32'h0, memf(32'h500)});
    sb.push_back('{1'b1, 1'b0, 32'h410, 32'h0, memf(32'h410)});
    sb.push_back('{1'b1, 1'b0, 32'h414, 32'h0, memf(32'h414)});
    sb.push_back('{1'b0, 1'b0, 32'h504, 32'h0, memf(32'h504)});
    fork
      port_d(6, 32'h400, ld);
      port_i(2, 32'h500, li);
    join
    check("starve_i_latency", 32'(li), 32'd30);
    @(posedge clk); #1;

    // Reset in the second BUSY cycle of a load, request held throughout.
    sb.push_back('{1'b1, 1'b0, 32'h600, 32'h0, memf(32'h600)});
    d_addr = 32'h600; d_we = 1'b0; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_enables", {30'b0, mem_w_enable, mem_r_enable}, 32'd0);
    check("abort_done_busy", {30'b0, d_done, busy}, 32'd0);
    check("abort_d_rdata", d_rdata, 32'h0);
    wait_done(1'b1, 40, lat);
    check("regrant_latency", 32'(lat), 32'd5);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;

    // Latency-1 build: back-to-back fetches, one enable cycle each.
    i1_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i1_addr = 32'(4 * k);
      cnt = 0; en = 0; ok = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (mem1_r_enable) en++;
        if (i1_done) begin cnt = c; ok = 1'b1; break; end
      end
      check("l1_done_seen", {31'b0, ok}, 32'd1);
      check("l1_latency", 32'(cnt), 32'd3);
      check("l1_enable_cycles", 32'(en), 32'd1);
      check("l1_i_rdata", i1_rdata, memf(32'(4 * k)));
      @(posedge clk); #1;
    end
    i1_req = 1'b0;
    @(negedge clk);
    check("l1_idle", {29'b0, busy1, mem1_r_enable, mem1_w_enable}, 32'd0);

    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
